// File: rtl/switch_allocator_pkg.sv
//------------------------------------------------------------------------------
// Module  : noc_params (package)
// Brief   : Router-wide sizing constants and shared switch-allocator types.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package noc_params;

  localparam int PORT_NUM = 5;
  localparam int VC_NUM   = 2;
  localparam int PORT_W   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int VC_W     = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef logic [PORT_W-1:0] port_t;
  typedef logic [VC_W-1:0]   vc_t;

  typedef enum logic [0:0] {
    LOCK_FREE = 1'b0,
    LOCK_HELD = 1'b1
  } lock_state_e;

  typedef struct packed {
    lock_state_e locked;
    port_t       owner_port;
    vc_t         owner_vc;
  } lock_t;

endpackage

`default_nettype wire

// File: rtl/switch_allocator_if.sv
//------------------------------------------------------------------------------
// Module  : sa_if
// Brief   : Request/grant bundle between input buffers, allocator and crossbar.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface sa_if;
  import noc_params::*;

  logic  [PORT_NUM-1:0][VC_NUM-1:0] req_i;
  port_t [PORT_NUM-1:0][VC_NUM-1:0] out_port_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] tail_i;
  logic  [PORT_NUM-1:0]             credit_ok_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0] vc_grant_o;
  port_t [PORT_NUM-1:0]             xb_sel_o;
  logic  [PORT_NUM-1:0]             xb_valid_o;

  modport master (
    output req_i, out_port_i, tail_i, credit_ok_i,
    input  vc_grant_o, xb_sel_o, xb_valid_o
  );

  modport slave (
    input  req_i, out_port_i, tail_i, credit_ok_i,
    output vc_grant_o, xb_sel_o, xb_valid_o
  );

endinterface

`default_nettype wire

// File: rtl/switch_allocator_arb.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_sync
// Brief   : N-way round-robin arbiter; pointer moves past the winner on update.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_sync #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic [N-1:0]  req_i,
  input  wire logic          update_i,
  output logic      [IW-1:0] grant_idx_o,
  output logic               valid_o
);

  logic [IW-1:0] r_ptr;
  int            w_cand;

  always_comb begin
    grant_idx_o = '0;
    valid_o     = 1'b0;
    w_cand      = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = (int'(r_ptr) + k) % N;
      if (!valid_o && req_i[w_cand]) begin
        valid_o     = 1'b1;
        grant_idx_o = IW'(w_cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (update_i && valid_o) begin
      r_ptr <= (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_allocator.sv
//------------------------------------------------------------------------------
// Module  : switch_allocator
// Brief   : Two-stage separable wormhole switch allocator with per-output locks.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module switch_allocator
  import noc_params::*;
(
  input wire logic clk,
  input wire logic rst,
  sa_if.slave      sa
);

  logic  [PORT_NUM-1:0][VC_NUM-1:0]   w_elig;
  vc_t                                w_s1_vc    [PORT_NUM];
  logic  [PORT_NUM-1:0]               w_s1_valid;
  port_t                              w_s1_tgt   [PORT_NUM];
  logic  [PORT_NUM-1:0][PORT_NUM-1:0] w_s2_req;
  port_t                              w_s2_idx   [PORT_NUM];
  logic  [PORT_NUM-1:0]               w_s2_valid;
  logic  [PORT_NUM-1:0]               w_in_win;
  lock_t                              r_lock     [PORT_NUM];
  lock_t                              w_lock_nxt [PORT_NUM];
  port_t                              w_o;

  // A locked output is reserved for its owner even when the owner is idle.
  always_comb begin
    w_elig = '0;
    w_o    = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_NUM; v++) begin
        w_o = sa.out_port_i[p][v];
        if (sa.req_i[p][v] && (int'(w_o) < PORT_NUM)) begin
          w_elig[p][v] = sa.credit_ok_i[w_o] &&
                         ((r_lock[w_o].locked == LOCK_FREE) ||
                          ((r_lock[w_o].owner_port == port_t'(p)) &&
                           (r_lock[w_o].owner_vc == vc_t'(v))));
        end
      end
    end
  end

  for (genvar p = 0; p < PORT_NUM; p++) begin : g_stage1
    rr_arbiter_sync #(.N(VC_NUM)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (w_elig[p]),
      .update_i    (w_in_win[p]),
      .grant_idx_o (w_s1_vc[p]),
      .valid_o     (w_s1_valid[p])
    );
  end

  always_comb begin
    w_s2_req = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      w_s1_tgt[p] = sa.out_port_i[p][w_s1_vc[p]];
      for (int o = 0; o < PORT_NUM; o++) begin
        w_s2_req[o][p] = w_s1_valid[p] && (w_s1_tgt[p] == port_t'(o));
      end
    end
  end

  for (genvar o = 0; o < PORT_NUM; o++) begin : g_stage2
    rr_arbiter_sync #(.N(PORT_NUM)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_i       (w_s2_req[o]),
      .update_i    (w_s2_valid[o]),
      .grant_idx_o (w_s2_idx[o]),
      .valid_o     (w_s2_valid[o])
    );
  end

  always_comb begin
    w_in_win      = '0;
    sa.vc_grant_o = '0;
    sa.xb_sel_o   = '0;
    sa.xb_valid_o = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      if (w_s2_valid[o]) begin
        w_in_win[w_s2_idx[o]] = 1'b1;
        if (!rst) begin
          sa.xb_valid_o[o]                              = 1'b1;
          sa.xb_sel_o[o]                                = w_s2_idx[o];
          sa.vc_grant_o[w_s2_idx[o]][w_s1_vc[w_s2_idx[o]]] = 1'b1;
        end
      end
    end
  end

  // Lock FSM next state: a tail releases, any other granted flit (re)claims.
  always_comb begin
    for (int o = 0; o < PORT_NUM; o++) begin
      w_lock_nxt[o] = r_lock[o];
      if (w_s2_valid[o]) begin
        if (sa.tail_i[w_s2_idx[o]][w_s1_vc[w_s2_idx[o]]]) begin
          w_lock_nxt[o] = '{locked: LOCK_FREE, owner_port: '0, owner_vc: '0};
        end else begin
          w_lock_nxt[o] = '{locked: LOCK_HELD, owner_port: w_s2_idx[o],
                            owner_vc: w_s1_vc[w_s2_idx[o]]};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int o = 0; o < PORT_NUM; o++) begin
      if (rst) begin
        r_lock[o] <= '{locked: LOCK_FREE, owner_port: '0, owner_vc: '0};
      end else begin
        r_lock[o] <= w_lock_nxt[o];
      end
    end
  end

endmodule

`default_nettype wire
